// File: rtl/grb_stream_decoder.sv
// grb_stream_decoder: receive-side decoder for the single-wire GRB LED protocol.
// Measures high/low run lengths of the synchronised line, rebuilds 24-bit
// {G,R,B} words MSB first, recognises the latch gap that ends a frame and
// flags stuck-high lines and partial words.
// Optional build macro: GRB_GLITCH_FILTER_EN adds a 2-sample majority filter
// after the synchroniser (single-cycle glitches ignored, +1 clk latency).
module grb_stream_decoder #(
  parameter int T_THRESH  = 60,
  parameter int T_MAXHIGH = 150,
  parameter int T_LATCH   = 5000,
  parameter int CW        = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] grb,
  output logic        grbValid,
  output logic        frameDone,
  output logic [7:0]  ledCount,
  output logic        bitErr,
  output logic        busy
);

  localparam logic [CW-1:0] C_THRESH  = CW'(T_THRESH);
  localparam logic [CW-1:0] C_MAXHIGH = CW'(T_MAXHIGH);
  localparam logic [CW-1:0] C_LATCH   = CW'(T_LATCH);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  typedef enum logic [1:0] {SSYNC, SIDLE, SHIGH, SLOW} state_t;

  logic          r_sync1, r_sync2;
  logic          w_ds;
  state_t        r_state, w_state;
  logic [CW-1:0] r_hcnt, w_hcnt;
  logic [CW-1:0] r_lcnt, w_lcnt;
  logic [23:0]   r_sreg, w_sreg;
  logic [4:0]    r_bitcnt, w_bitcnt;
  logic [7:0]    r_wcnt, w_wcnt;
  logic [23:0]   r_grb, w_grb;
  logic [7:0]    r_led_count, w_led_count;
  logic          r_grb_valid, w_grb_valid;
  logic          r_frame_done, w_frame_done;
  logic          r_bit_err, w_bit_err;
  logic [23:0]   w_new_word;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // so this really is two stages rather than a single wire.
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GRB_GLITCH_FILTER_EN
  logic r_sync3, r_ds_hold;

  // ds follows the synchroniser only after two equal consecutive samples.
  assign w_ds = (r_sync2 == r_sync3) ? r_sync2 : r_ds_hold;

  // Previous synchroniser sample and the held filter output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync3   <= 1'b0;
      r_ds_hold <= 1'b0;
    end else begin
      r_sync3   <= r_sync2;
      r_ds_hold <= w_ds;
    end
  end
`else
  assign w_ds = r_sync2;
`endif

  // Word formed by shifting the bit decoded from the current high run.
  assign w_new_word = {r_sreg[22:0], (r_hcnt >= C_THRESH)};

  // Next-state and next-output logic for the pulse-width decoder.
  always_comb begin
    // NOTE: every target gets a default first; a path that leaves one
    // unassigned would otherwise infer a latch.
    w_state      = r_state;
    w_hcnt       = r_hcnt;
    w_lcnt       = r_lcnt;
    w_sreg       = r_sreg;
    w_bitcnt     = r_bitcnt;
    w_wcnt       = r_wcnt;
    w_grb        = r_grb;
    w_led_count  = r_led_count;
    w_grb_valid  = 1'b0;
    w_frame_done = 1'b0;
    w_bit_err    = 1'b0;
    unique case (r_state)
      SSYNC: begin
        // Wait for a full latch gap so decoding never starts mid-frame.
        if (w_ds) begin
          w_lcnt = '0;
        end else if (r_lcnt >= C_LATCH - C_ONE) begin
          w_lcnt  = C_LATCH;
          w_state = SIDLE;
        end else begin
          w_lcnt = r_lcnt + C_ONE;
        end
      end
      SIDLE: begin
        if (w_ds) begin
          w_hcnt  = C_ONE;
          w_state = SHIGH;
        end
      end
      SHIGH: begin
        if (w_ds) begin
          if (r_hcnt >= C_MAXHIGH - C_ONE) begin
            // Line stuck high: drop the frame and resynchronise.
            w_hcnt    = C_MAXHIGH;
            w_bit_err = 1'b1;
            w_bitcnt  = '0;
            w_wcnt    = '0;
            w_lcnt    = '0;
            w_state   = SSYNC;
          end else begin
            w_hcnt = r_hcnt + C_ONE;
          end
        end else begin
          w_sreg  = w_new_word;
          w_lcnt  = C_ONE;
          w_state = SLOW;
          if (r_bitcnt == 5'd23) begin
            w_grb       = w_new_word;
            w_grb_valid = 1'b1;
            w_bitcnt    = '0;
            w_wcnt      = (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;
          end else begin
            w_bitcnt = r_bitcnt + 5'd1;
          end
        end
      end
      SLOW: begin
        if (w_ds) begin
          w_hcnt  = C_ONE;
          w_state = SHIGH;
        end else if (r_lcnt >= C_LATCH - C_ONE) begin
          w_lcnt       = C_LATCH;
          w_frame_done = 1'b1;
          w_led_count  = r_wcnt;
          w_wcnt       = '0;
          w_state      = SIDLE;
          if (r_bitcnt != 5'd0) begin
            w_bit_err = 1'b1;
            w_bitcnt  = '0;
          end
        end else begin
          w_lcnt = r_lcnt + C_ONE;
        end
      end
      default: w_state = SSYNC;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= SSYNC;
      r_hcnt       <= '0;
      r_lcnt       <= '0;
      r_sreg       <= '0;
      r_bitcnt     <= '0;
      r_wcnt       <= '0;
      r_grb        <= '0;
      r_led_count  <= '0;
      r_grb_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_bit_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hcnt       <= w_hcnt;
      r_lcnt       <= w_lcnt;
      r_sreg       <= w_sreg;
      r_bitcnt     <= w_bitcnt;
      r_wcnt       <= w_wcnt;
      r_grb        <= w_grb;
      r_led_count  <= w_led_count;
      r_grb_valid  <= w_grb_valid;
      r_frame_done <= w_frame_done;
      r_bit_err    <= w_bit_err;
    end
  end

  assign grb       = r_grb;
  assign grbValid  = r_grb_valid;
  assign frameDone = r_frame_done;
  assign ledCount  = r_led_count;
  assign bitErr    = r_bit_err;
  assign busy      = (r_state == SHIGH) || (r_state == SLOW);

endmodule

// File: tb/tb_grb_stream_decoder.sv
// tb_grb_stream_decoder: randomized self-checking bench for grb_stream_decoder.
// A reference model turns each transmitted pulse into a bit (high >= threshold
// means 1), packs 24 bits per word and predicts words, ledCount and bitErr per
// frame; a negedge monitor records what the decoder actually emits.
module tb_grb_stream_decoder;

  localparam int T_THRESH  = 60;
  localparam int T_MAXHIGH = 150;
  localparam int T_LATCH   = 5000;
`ifdef GRB_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] grb;
  logic        grbValid, frameDone, bitErr, busy;
  logic [7:0]  ledCount;

  grb_stream_decoder dut (
    .clk(clk), .reset(rst_n), .din(din), .grb(grb), .grbValid(grbValid),
    .frameDone(frameDone), .ledCount(ledCount), .bitErr(bitErr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall = 0;

  // Observations
  logic [23:0] obs_words[$];
  int          obs_vcyc[$];
  int          obs_fcyc[$];
  logic [7:0]  obs_fled[$];
  logic        obs_ferr[$];
  int          obs_ecyc[$];
  int          coinc = 0;
  int          busy_gaps = 0;
  bit          busy_watch = 0;
  bit          arm_pending = 0;
  int          arm_at = 0;

  // Reference model state
  logic [23:0] m_word;
  int          m_nbits;
  int          m_nw;
  logic [23:0] exp_words[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (grbValid) begin
        obs_words.push_back(grb);
        obs_vcyc.push_back(cyc);
      end
      if (frameDone) begin
        obs_fcyc.push_back(cyc);
        obs_fled.push_back(ledCount);
        obs_ferr.push_back(bitErr);
      end
      if (bitErr && !frameDone) obs_ecyc.push_back(cyc);
      if (grbValid && (frameDone || bitErr)) coinc++;
      if (arm_pending && cyc == arm_at) begin
        busy_watch  = 1;
        arm_pending = 0;
      end
      if (busy_watch && !frameDone && !busy) busy_gaps++;
      if (frameDone) busy_watch = 0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    obs_words.delete(); obs_vcyc.delete(); obs_fcyc.delete();
    obs_fled.delete(); obs_ferr.delete(); obs_ecyc.delete();
    exp_words.delete();
    m_word = '0; m_nbits = 0; m_nw = 0;
  endtask

  // One pulse: hi cycles high, lo cycles low; the model decodes it by width.
  task automatic send_bit(int hi, int lo);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    last_fall = cyc;
    tick(lo);
    m_word = {m_word[22:0], (hi >= T_THRESH)};
    m_nbits++;
    if (m_nbits == 24) begin
      exp_words.push_back(m_word);
      m_nbits = 0;
      m_nw++;
    end
  endtask

  task automatic send_word(logic [23:0] w, bit rnd);
    for (int i = 23; i >= 0; i--) begin
      int hi;
      int lo;
      if (rnd) begin
        hi = w[i] ? int'($urandom_range(100, 60)) : int'($urandom_range(59, 3));
        lo = int'($urandom_range(40, 3));
      end else begin
        hi = w[i] ? 80 : 40;
        lo = w[i] ? 45 : 85;
      end
      send_bit(hi, lo);
    end
  endtask

  task automatic latch_gap();
    din = 1'b0;
    tick(T_LATCH + 10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    tick(3);
    n_cmp++;
    if ({grb, grbValid, frameDone, ledCount, bitErr, busy} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grb=%h v=%b fd=%b lc=%0d err=%b busy=%b, expected all 0",
               grb, grbValid, frameDone, ledCount, bitErr, busy);
    end
    rst_n = 1'b1;
    clear_all();
    tick(T_LATCH + 5);
    n_cmp++;
    if (obs_fcyc.size() != 0 || obs_ecyc.size() != 0) begin
      n_bad++;
      $display("FAIL sync_no_frame: got %0d frameDone %0d bitErr, expected 0 0",
               obs_fcyc.size(), obs_ecyc.size());
    end
    n_cmp++;
    if ({grb, ledCount, busy} !== 33'd0) begin
      n_bad++;
      $display("FAIL sync_outputs: got grb=%h lc=%0d busy=%b, expected 0", grb, ledCount, busy);
    end
  endtask

  task automatic test_single_word();
    int lf;
    clear_all();
    send_word(24'hA5C33C, 1'b0);
    lf = last_fall;
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d words, expected 1", obs_words.size());
    end else begin
      n_cmp++;
      if (obs_words[0] !== 24'hA5C33C) begin
        n_bad++;
        $display("FAIL single_word: got %h, expected a5c33c", obs_words[0]);
      end
      n_cmp++;
      if (obs_vcyc[0] - lf != LAT) begin
        n_bad++;
        $display("FAIL single_latency: got %0d, expected %0d", obs_vcyc[0] - lf, LAT);
      end
    end
    n_cmp++;
    if (obs_fcyc.size() != 1) begin
      n_bad++;
      $display("FAIL single_frames: got %0d frames, expected 1", obs_fcyc.size());
    end else begin
      n_cmp++;
      if (obs_fled[0] !== 8'd1 || obs_ferr[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL single_frame: got lc=%0d err=%b, expected lc=1 err=0", obs_fled[0], obs_ferr[0]);
      end
      n_cmp++;
      if (obs_fcyc[0] - lf != T_LATCH + LAT - 1) begin
        n_bad++;
        $display("FAIL latch_latency: got %0d, expected %0d", obs_fcyc[0] - lf, T_LATCH + LAT - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w[3];
    w[0] = 24'hFF0000; w[1] = 24'h00FF00; w[2] = 24'h0000FF;
    clear_all();
    busy_gaps   = 0;
    arm_at      = cyc + LAT;
    arm_pending = 1;
    for (int k = 0; k < 3; k++) send_word(w[k], 1'b0);
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d words, expected 3", obs_words.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_words[k] !== w[k]) begin
          n_bad++;
          $display("FAIL b2b_word%0d: got %h, expected %h", k, obs_words[k], w[k]);
        end
      end
    end
    n_cmp++;
    if (obs_fled.size() != 1 || obs_fled[0] !== 8'd3) begin
      n_bad++;
      $display("FAIL b2b_ledcount: got %0d frames lc=%0d, expected 1 frame lc=3",
               obs_fled.size(), (obs_fled.size() > 0) ? obs_fled[0] : 8'd0);
    end
    n_cmp++;
    if (busy_gaps != 0 || busy !== 1'b0 || busy_watch) begin
      n_bad++;
      $display("FAIL b2b_busy: got %0d low cycles in frame, busy=%b after, expected 0 0",
               busy_gaps, busy);
    end
  endtask

  task automatic test_partial();
    clear_all();
    for (int i = 0; i < 10; i++)
      send_bit(int'($urandom_range(140, 3)), int'($urandom_range(60, 3)));
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 0) begin
      n_bad++;
      $display("FAIL partial_words: got %0d words, expected 0", obs_words.size());
    end
    n_cmp++;
    if (obs_fcyc.size() != 1 || obs_fled[0] !== 8'd0 || obs_ferr[0] !== 1'b1 || obs_ecyc.size() != 0) begin
      n_bad++;
      $display("FAIL partial_frame: got %0d frames err=%b lc=%0d solo_err=%0d, expected 1 1 0 0",
               obs_fcyc.size(), (obs_ferr.size() > 0) ? obs_ferr[0] : 1'b0,
               (obs_fled.size() > 0) ? obs_fled[0] : 8'd0, obs_ecyc.size());
    end
  endtask

  task automatic test_boundaries();
    int his[4];
    his[0] = 59; his[1] = 60; his[2] = 3; his[3] = 149;
    clear_all();
    for (int i = 0; i < 24; i++) send_bit(his[(i * 3 + i / 4) % 4], 20);
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 1 || exp_words.size() != 1) begin
      n_bad++;
      $display("FAIL bound_count: got %0d words, expected 1", obs_words.size());
    end else begin
      n_cmp++;
      if (obs_words[0] !== exp_words[0]) begin
        n_bad++;
        $display("FAIL bound_word: got %h, expected %h", obs_words[0], exp_words[0]);
      end
    end
    n_cmp++;
    if (obs_ecyc.size() != 0) begin
      n_bad++;
      $display("FAIL bound_err: got %0d bitErr, expected 0 (149 high is legal)", obs_ecyc.size());
    end
  endtask

  task automatic test_stuck_high();
    int c;
    clear_all();
    for (int i = 0; i < 5; i++) send_bit(80, 45);
    din = 1'b1;
    c = cyc;
    tick(200);
    din = 1'b0;
    tick(50);
    n_cmp++;
    if (obs_ecyc.size() != 1) begin
      n_bad++;
      $display("FAIL stuck_err_count: got %0d, expected 1", obs_ecyc.size());
    end else begin
      n_cmp++;
      if (obs_ecyc[0] - c != T_MAXHIGH + LAT - 1) begin
        n_bad++;
        $display("FAIL stuck_err_time: got %0d, expected %0d", obs_ecyc[0] - c, T_MAXHIGH + LAT - 1);
      end
    end
    send_word($urandom_range(24'hFFFFFF, 0), 1'b1);
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 0 || obs_fcyc.size() != 0) begin
      n_bad++;
      $display("FAIL stuck_resync: got %0d words %0d frames, expected 0 0",
               obs_words.size(), obs_fcyc.size());
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 2; f++) begin
      int nw;
      int nb;
      clear_all();
      nw = int'($urandom_range(2, 1));
      nb = int'($urandom_range(8, 0));
      for (int k = 0; k < nw; k++) send_word($urandom_range(24'hFFFFFF, 0), 1'b1);
      for (int k = 0; k < nb; k++)
        send_bit(int'($urandom_range(140, 3)), int'($urandom_range(40, 3)));
      latch_gap();
      n_cmp++;
      if (obs_words.size() != exp_words.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_count: got %0d words, expected %0d", f, obs_words.size(), exp_words.size());
      end else begin
        for (int k = 0; k < exp_words.size(); k++) begin
          n_cmp++;
          if (obs_words[k] !== exp_words[k]) begin
            n_bad++;
            $display("FAIL rnd%0d_word%0d: got %h, expected %h", f, k, obs_words[k], exp_words[k]);
          end
        end
      end
      n_cmp++;
      if (obs_fcyc.size() != 1 || obs_fled[0] != ((m_nw > 255) ? 255 : m_nw) ||
          obs_ferr[0] !== (m_nbits != 0)) begin
        n_bad++;
        $display("FAIL rnd%0d_frame: got %0d frames lc=%0d err=%b, expected 1 lc=%0d err=%b",
                 f, obs_fcyc.size(), (obs_fled.size() > 0) ? obs_fled[0] : 8'd0,
                 (obs_ferr.size() > 0) ? obs_ferr[0] : 1'b0, m_nw, (m_nbits != 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int i = 0; i < 12; i++) send_bit(80, 45);
    din = 1'b1;
    tick(20);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grb, grbValid, frameDone, ledCount, bitErr, busy} !== 36'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got grb=%h lc=%0d busy=%b, expected 0",
               grb, ledCount, busy);
    end
    tick(1);
    din = 1'b0;
    rst_n = 1'b1;
    clear_all();
    tick(10);
    send_word($urandom_range(24'hFFFFFF, 0), 1'b1);
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 0 || obs_fcyc.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_resync: got %0d words %0d frames, expected 0 0",
               obs_words.size(), obs_fcyc.size());
    end
  endtask

  // Decoding resumes after the resync gap; with the filter, a one-cycle
  // high glitch in each low phase must add no extra bit.
  task automatic test_resume();
    logic [23:0] w;
    clear_all();
    w = $urandom_range(24'hFFFFFF, 0);
`ifdef GRB_GLITCH_FILTER_EN
    for (int i = 23; i >= 0; i--) begin
      din = 1'b1; tick(w[i] ? 80 : 40);
      din = 1'b0; tick(20);
      din = 1'b1; tick(1);
      din = 1'b0; tick(25);
    end
    exp_words.push_back(w);
    m_nw = 1;
`else
    send_word(w, 1'b1);
`endif
    latch_gap();
    n_cmp++;
    if (obs_words.size() != 1 || obs_words[0] !== exp_words[0]) begin
      n_bad++;
      $display("FAIL resume_word: got %0d words first=%h, expected 1 word %h",
               obs_words.size(), (obs_words.size() > 0) ? obs_words[0] : 24'd0, exp_words[0]);
    end
    n_cmp++;
    if (obs_fled.size() != 1 || obs_fled[0] !== 8'd1 || obs_ferr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_frame: got %0d frames, expected 1 frame lc=1 err=0", obs_fled.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial();
    test_boundaries();
    test_stuck_high();
    test_random_frames();
    test_reset_mid();
    test_resume();
    n_cmp++;
    if (coinc != 0) begin
      n_bad++;
      $display("FAIL coincidence: got %0d grbValid cycles with frameDone/bitErr, expected 0", coinc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
